// File: rtl/pc_seq.sv
// Program-counter sequencer: fetches one instruction word per FETCH/WAIT handshake,
// holds it in PRG for an EXEC cycle, then advances or jumps the PC.
module pc_seq #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        ROM_REQ,
    output logic [15:0] ROM_ADDR,
    input  logic        ROM_ACK,
    input  logic [15:0] ROM_DATA,
    output logic [15:0] PRG,
    output logic        PRG_VALID,
    input  logic        STALL,
    input  logic        JUMP,
    input  logic        PAGE,
    input  logic        PAGE0,
    input  logic [7:0]  TGT,
    input  logic [7:0]  ACC,
    output logic [15:0] PC
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] prg_q, prg_d;

    // PAGE outranks PAGE0; both are don't-care without JUMP.
    function automatic logic [15:0] next_pc(
        input logic [15:0] pc,
        input logic        jump,
        input logic        page,
        input logic        page0,
        input logic [7:0]  tgt,
        input logic [7:0]  acc
    );
        if (!jump)
            return pc + 16'd1;
        else if (page)
            return {acc, tgt};
        else if (page0)
            return {8'h00, tgt};
        else
            return {pc[15:8], tgt};
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            prg_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            prg_q   <= prg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        prg_d   = prg_q;
        case (state_q)
            S_FETCH, S_WAIT: begin
                if (ROM_ACK) begin
                    prg_d   = ROM_DATA;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_EXEC: begin
                if (!STALL) begin
                    pc_d    = next_pc(pc_q, JUMP, PAGE, PAGE0, TGT, ACC);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks the handshake outputs in the same cycle, not just the next.
    always_comb begin
        ROM_REQ   = !RST && ((state_q == S_FETCH) || (state_q == S_WAIT));
        PRG_VALID = !RST && (state_q == S_EXEC);
        ROM_ADDR  = pc_q;
        PC        = pc_q;
        PRG       = prg_q;
    end

endmodule
